// File: rtl/dec_pkg.sv
// Shared widths, output type and idle constants for the 3-to-8 decoder.
package dec_pkg;

  localparam int unsigned DEC_IN_W  = 3;
  localparam int unsigned DEC_OUT_W = 2 ** DEC_IN_W;

  typedef logic [DEC_OUT_W-1:0] dec_out_t;

  localparam dec_out_t DEC_IDLE_HI = dec_out_t'(8'h00);
  localparam dec_out_t DEC_IDLE_LO = dec_out_t'(8'hFF);

  // An X/Z select propagates X through the shift rather than a false one-hot.
  function automatic dec_out_t dec_onehot(input logic en, input logic [DEC_IN_W-1:0] a);
    dec_onehot = en ? (dec_out_t'(1) << a) : DEC_IDLE_HI;
  endfunction

endpackage

// File: rtl/dec_3to8_core.sv
// Pure combinational decode of {en, a} to an active-high one-hot vector.
module dec_3to8_core
  import dec_pkg::*;
(
  input  logic                en,
  input  logic [DEC_IN_W-1:0] a,
  output dec_out_t            d
);

  assign d = dec_onehot(en, a);

endmodule

// File: rtl/dec_3to8.sv
// 3-to-8 select decoder with optional output inversion and optional output flop.
module dec_3to8
  import dec_pkg::*;
#(
  parameter bit REGISTERED     = 1'b1,
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DEC_IN_W-1:0] A,
  output dec_out_t            D
);

  localparam dec_out_t IDLE = ACTIVE_LOW_OUT ? DEC_IDLE_LO : DEC_IDLE_HI;

  dec_out_t dec_val;
  dec_out_t dec_pol;

  dec_3to8_core u_core (
    .en (en),
    .a  (A),
    .d  (dec_val)
  );

  assign dec_pol = ACTIVE_LOW_OUT ? ~dec_val : dec_val;

  if (REGISTERED) begin : g_reg
    dec_out_t d_q;

    // Single flop stage; reset forces the idle pattern immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= IDLE;
      end else begin
        d_q <= dec_pol;
      end
    end

    assign D = d_q;
  end else begin : g_comb
    // Clock and reset have no function in the glue-logic variant.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign D = dec_pol;
  end

endmodule

// File: tb/tb_dec_3to8.sv
// Directed bench for dec_3to8: registered, active-low and combinational variants.
module tb_dec_3to8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] a;
  logic [7:0] d_reg;
  logic [7:0] d_lo;
  logic [7:0] d_comb;

  int n_cmp;
  int n_err;

  logic [7:0] exp_tbl [8];
  logic [7:0] exp_v;

  dec_3to8 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .D(d_reg)
  );

  dec_3to8 #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .D(d_lo)
  );

  dec_3to8 #(.REGISTERED(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .D(d_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Inputs change at the falling edge; registered outputs sampled 1 after the rising edge.
  task automatic step_and_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n   = 1'b0;
    en      = 1'b1;
    a       = 3'd0;

    // Reset held: outputs stay idle whatever A does.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = 3'(i);
      step_and_sample();
      check($sformatf("rst_hold_reg_a%0d", i), d_reg, 8'h00);
      check($sformatf("rst_hold_lo_a%0d", i), d_lo, 8'hFF);
    end

    // Exhaustive sweep, one cycle of latency.
    @(negedge clk);
    rst_n = 1'b1;
    a     = 3'd0;
    #1;
    check("first_before_edge", d_reg, 8'h00);
    step_and_sample();
    check("sweep_a0", d_reg, exp_tbl[0]);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      a = 3'(i);
      #1;
      check($sformatf("latency_hold_a%0d", i), d_reg, exp_tbl[i-1]);
      step_and_sample();
      check($sformatf("sweep_a%0d", i), d_reg, exp_tbl[i]);
    end

    // Enable control.
    @(negedge clk);
    en = 1'b0;
    a  = 3'd5;
    step_and_sample();
    check("en0_a5", d_reg, 8'h00);
    @(negedge clk);
    en = 1'b1;
    step_and_sample();
    check("en1_a5", d_reg, 8'h20);
    @(negedge clk);
    en = 1'b0;
    step_and_sample();
    check("en_drop", d_reg, 8'h00);
    @(negedge clk);
    en = 1'b1;
    step_and_sample();
    check("en1_a5_again", d_reg, 8'h20);

    // Asynchronous reset mid-cycle, well before the next rising edge.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_reg", d_reg, 8'h00);
    check("async_rst_lo", d_lo, 8'hFF);
    step_and_sample();
    check("async_rst_hold", d_reg, 8'h00);

    // Active-low variant after release.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    a     = 3'd3;
    step_and_sample();
    check("lo_a3", d_lo, 8'hF7);
    check("hi_a3", d_reg, 8'h08);
    @(negedge clk);
    a = 3'd7;
    step_and_sample();
    check("lo_a7", d_lo, 8'h7F);
    @(negedge clk);
    en = 1'b0;
    step_and_sample();
    check("lo_disabled", d_lo, 8'hFF);

    // Combinational variant: same-timestep response, no clock edge between.
    @(negedge clk);
    a  = 3'd6;
    en = 1'b1;
    #1;
    check("comb_a6", d_comb, 8'h40);
    check("comb_vs_reg_pending", d_reg, 8'h00);
    en = 1'b0;
    #1;
    check("comb_en0", d_comb, 8'h00);
    rst_n = 1'b0;
    a     = 3'd2;
    en    = 1'b1;
    #1;
    check("comb_ignores_rst", d_comb, 8'h04);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      a  = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      #1;
      exp_v = en ? exp_tbl[a] : 8'h00;
      check("comb_onehot0", {7'd0, $onehot0(d_comb)}, 8'h01);
      check("comb_rand", d_comb, exp_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
